// File: rtl/bullet_fire_scheduler.sv
// bullet_fire_scheduler: converts the shoot level into rate-limited launch
// requests. It owns a pool of NUM_SLOTS bullet slots, picks the lowest free
// slot for each launch, and hands that slot to the bullet datapath.
// Latency: shoot sampled in IDLE raises fire_valid one cycle later. With shoot
// held, AUTO_FIRE=1 and fire_ready=1, one launch is accepted every COOLDOWN+2 cycles.
// Backpressure: fire_valid/fire_slot hold until fire_ready. A press with no
// free slot is dropped and never queued.
//
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   shoot        - shoot level from the keyboard block
//   game_active  - launches permitted only while high; dropping it aborts a pending request
//   slot_done    - one-cycle pulse per slot when its bullet expires or hits
//   fire_ready   - bullet datapath accepts the launch
//   fire_valid   - launch request pending
//   fire_slot    - slot to launch into; stable while fire_valid is high
//   slot_busy    - per-slot in-flight flags
//   shots_fired  - accepted launch count, wraps

module bullet_fire_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int COOLDOWN  = 8,
  parameter int CNT_W     = 16,
  parameter bit AUTO_FIRE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shoot,
  input  logic                 game_active,
  input  logic [NUM_SLOTS-1:0] slot_done,
  input  logic                 fire_ready,
  output logic                 fire_valid,
  output logic [SLOT_W-1:0]    fire_slot,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [CNT_W-1:0]     shots_fired
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_COOL     = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  // Counter only needs to hold COOLDOWN-1.
  localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  logic [1:0]           r_state;
  logic                 r_fire_valid;
  logic [SLOT_W-1:0]    r_fire_slot;
  logic [NUM_SLOTS-1:0] r_slot_busy;
  logic [CNT_W-1:0]     r_shots;
  logic [CD_W-1:0]      r_cnt;

  logic [SLOT_W-1:0]    w_free_idx;
  logic                 w_any_free;
  logic                 w_accept;
  logic [NUM_SLOTS-1:0] w_set_mask;

  // Priority search from the top down, so the lowest free index wins.
  // It reads the registered busy vector, so a slot freed by slot_done in this
  // cycle becomes eligible only from the next cycle.
  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_slot_busy[i]) begin
        w_free_idx = SLOT_W'(i);
      end
    end
  end

  assign w_any_free = |(~r_slot_busy);

  // A game_active drop in REQ aborts the request, even when fire_ready is
  // high in the same cycle.
  assign w_accept   = (r_state == ST_REQ) && game_active && fire_ready;
  assign w_set_mask = w_accept ? (NUM_SLOTS'(1) << r_fire_slot) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_fire_valid <= 1'b0;
      r_fire_slot  <= '0;
      r_slot_busy  <= '0;
      r_shots      <= '0;
      r_cnt        <= '0;
    end else begin
      // A done pulse and an accept on different slots both take effect.
      // A done pulse on an already-free slot does nothing.
      r_slot_busy <= (r_slot_busy & ~slot_done) | w_set_mask;

      case (r_state)
        ST_IDLE: begin
          if (shoot && game_active && w_any_free) begin
            r_state      <= ST_REQ;
            r_fire_valid <= 1'b1;
            r_fire_slot  <= w_free_idx;
          end
        end
        ST_REQ: begin
          // A shoot release does not withdraw the request. Only an abort or
          // an accept ends it.
          if (!game_active) begin
            r_state      <= ST_IDLE;
            r_fire_valid <= 1'b0;
          end else if (fire_ready) begin
            r_state      <= ST_COOL;
            r_fire_valid <= 1'b0;
            r_shots      <= r_shots + CNT_W'(1);
            r_cnt        <= CD_W'(COOLDOWN - 1);
          end
        end
        ST_COOL: begin
          if (r_cnt == '0) begin
            r_state <= AUTO_FIRE ? ST_IDLE : ST_WAIT_REL;
          end else begin
            r_cnt <= r_cnt - CD_W'(1);
          end
        end
        default: begin
          if (!shoot) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign fire_valid  = r_fire_valid;
  assign fire_slot   = r_fire_slot;
  assign slot_busy   = r_slot_busy;
  assign shots_fired = r_shots;

endmodule
